// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: control-word bit positions, opcodes, default widths,
// bus-driver indices and the control-word decoder.
package sap1_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    localparam int CW_W    = 12;
    localparam int CW_CP   = 11;
    localparam int CW_EP   = 10;
    localparam int CW_LM_N = 9;
    localparam int CW_CE_N = 8;
    localparam int CW_LI_N = 7;
    localparam int CW_EI_N = 6;
    localparam int CW_LA_N = 5;
    localparam int CW_EA   = 4;
    localparam int CW_SU   = 3;
    localparam int CW_EU   = 2;
    localparam int CW_LB_N = 1;
    localparam int CW_LO_N = 0;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    // Bus drivers, listed from highest to lowest priority.
    localparam int NUM_DRV = 5;
    localparam int DRV_EP  = 0;
    localparam int DRV_CE  = 1;
    localparam int DRV_EI  = 2;
    localparam int DRV_EA  = 3;
    localparam int DRV_EU  = 4;

    // Control word with every strobe converted to active-high.
    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } ctrl_t;

    function automatic ctrl_t decode_cw(input logic [CW_W-1:0] cw);
        ctrl_t c;
        c.cp = cw[CW_CP];
        c.ep = cw[CW_EP];
        c.lm = ~cw[CW_LM_N];
        c.ce = ~cw[CW_CE_N];
        c.li = ~cw[CW_LI_N];
        c.ei = ~cw[CW_EI_N];
        c.la = ~cw[CW_LA_N];
        c.ea = cw[CW_EA];
        c.su = cw[CW_SU];
        c.eu = cw[CW_EU];
        c.lb = ~cw[CW_LB_N];
        c.lo = ~cw[CW_LO_N];
        return c;
    endfunction

endpackage

// File: rtl/sap1_alu.sv
// SAP-1 adder-subtractor: A+B, or A+~B+1 when su is set, with carry-out
// (for subtraction carry=1 means no borrow).
module sap1_alu
    import sap1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              su,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_b_inv
            assign b_eff[gi] = b[gi] ^ su;
        end
    endgenerate

    assign sum    = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, su};
    assign result = sum[DATA_W-1:0];
    assign carry  = sum[DATA_W];

endmodule

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: W bus, PC, MAR, 16x8 RAM with program-load port, IR, A, B, ALU,
// OUT and a sticky halt flag. Define SAP1_FLAGS_EN to add carry_flag/zero_flag.
module sap1_datapath
    import sap1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW_W-1:0]   cw_bus,
    output logic [3:0]        opcode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              halted,
    output logic              bus_conflict,
`ifdef SAP1_FLAGS_EN
    output logic              carry_flag,
    output logic              zero_flag,
`endif
    output logic [DATA_W-1:0] w_bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    ctrl_t             ctrl;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] mar_reg;
    logic [DATA_W-1:0] ir_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] out_reg;
    logic              halted_reg;

    logic [DATA_W-1:0] ram_mem [DEPTH];
    logic [DATA_W-1:0] ram_rd;

    logic [DATA_W-1:0] alu_result;
    logic [NUM_DRV-1:0] drv_en;
    logic [DATA_W-1:0] drv_val [NUM_DRV];
    logic [DATA_W-1:0] bus_next;
    logic              conflict_next;
    logic              drv_found;

    assign ctrl   = decode_cw(cw_bus);
    assign ram_rd = ram_mem[mar_reg];

    assign drv_en[DRV_EP]  = ctrl.ep;
    assign drv_en[DRV_CE]  = ctrl.ce;
    assign drv_en[DRV_EI]  = ctrl.ei;
    assign drv_en[DRV_EA]  = ctrl.ea;
    assign drv_en[DRV_EU]  = ctrl.eu;
    assign drv_val[DRV_EP] = DATA_W'(pc_reg);
    assign drv_val[DRV_CE] = ram_rd;
    assign drv_val[DRV_EI] = DATA_W'(ir_reg[ADDR_W-1:0]);
    assign drv_val[DRV_EA] = a_reg;
    assign drv_val[DRV_EU] = alu_result;

    // First enabled driver in priority order wins; any later enabled one flags a conflict.
    always_comb begin
        bus_next      = '0;
        conflict_next = 1'b0;
        drv_found     = 1'b0;
        for (int i = 0; i < NUM_DRV; i++) begin
            if (drv_en[i]) begin
                if (drv_found) begin
                    conflict_next = 1'b1;
                end else begin
                    bus_next = drv_val[i];
                end
                drv_found = 1'b1;
            end
        end
    end

`ifdef SAP1_FLAGS_EN
    logic alu_carry;
    logic carry_reg;
    logic zero_reg;

    sap1_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (a_reg),
        .b      (b_reg),
        .su     (ctrl.su),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_reg <= 1'b0;
            zero_reg  <= 1'b0;
        end else if (!halted_reg && ctrl.la && ctrl.eu) begin
            carry_reg <= alu_carry;
            zero_reg  <= (alu_result == '0);
        end
    end

    assign carry_flag = carry_reg;
    assign zero_flag  = zero_reg;
`else
    logic alu_carry_unused;

    sap1_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (a_reg),
        .b      (b_reg),
        .su     (ctrl.su),
        .result (alu_result),
        .carry  (alu_carry_unused)
    );
`endif

    // Program-load port stays live while halted; reset blocks it but never clears RAM.
    always_ff @(posedge clk) begin
        if (prog_we && !rst) begin
            ram_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg     <= '0;
            mar_reg    <= '0;
            ir_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            out_reg    <= '0;
            halted_reg <= 1'b0;
        end else if (!halted_reg) begin
            if (ctrl.cp) begin
                pc_reg <= pc_reg + ADDR_W'(1);
            end
            if (ctrl.lm) begin
                mar_reg <= bus_next[ADDR_W-1:0];
            end
            if (ctrl.li) begin
                ir_reg <= bus_next;
                if (bus_next[DATA_W-1 -: 4] == 4'(OP_HLT)) begin
                    halted_reg <= 1'b1;
                end
            end
            if (ctrl.la) begin
                a_reg <= bus_next;
            end
            if (ctrl.lb) begin
                b_reg <= bus_next;
            end
            if (ctrl.lo) begin
                out_reg <= a_reg;
            end
        end
    end

    assign opcode       = ir_reg[DATA_W-1 -: 4];
    assign out_data     = out_reg;
    assign halted       = halted_reg;
    assign bus_conflict = conflict_next;
    assign w_bus        = bus_next;

endmodule

// File: tb/tb_sap1_datapath.sv
// Directed bench for sap1_datapath: the bench acts as the microcode controller and
// keeps a register-transfer model of the machine that is compared every cycle.
module tb_sap1_datapath;

    localparam logic [11:0] NOP    = 12'h3E3;
    localparam logic [11:0] RD_A   = 12'h3F3;
    localparam logic [11:0] RD_PC  = 12'h7E3;
    localparam logic [11:0] RD_RAM = 12'h2E3;
    localparam logic [11:0] RD_OPR = 12'h3A3;
    localparam logic [11:0] CP_ONE = 12'hBE3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] cw_bus = NOP;
    logic [3:0]  opcode;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = 4'h0;
    logic [7:0]  prog_data = 8'h00;
    logic [7:0]  out_data;
    logic        halted;
    logic        bus_conflict;
    logic [7:0]  w_bus;
`ifdef SAP1_FLAGS_EN
    logic        carry_flag;
    logic        zero_flag;
`endif

    always #5 clk = ~clk;

    sap1_datapath dut (
        .clk          (clk),
        .rst          (rst),
        .cw_bus       (cw_bus),
        .opcode       (opcode),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .out_data     (out_data),
        .halted       (halted),
        .bus_conflict (bus_conflict),
`ifdef SAP1_FLAGS_EN
        .carry_flag   (carry_flag),
        .zero_flag    (zero_flag),
`endif
        .w_bus        (w_bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_ram [16];
    logic [3:0] m_pc, m_mar;
    logic [7:0] m_ir, m_a, m_b, m_out;
    logic       m_halt;
    logic       m_c, m_z;
    bit         model_valid = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {carry, result}; subtraction carry means "no borrow".
    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic su);
        if (su) return {(a >= b), 8'(a - b)};
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [7:0] exp_bus(input logic [11:0] cw);
        logic [8:0] alu;
        alu = alu_model(m_a, m_b, cw[3]);
        if (cw[10])  return {4'h0, m_pc};
        if (!cw[8])  return m_ram[m_mar];
        if (!cw[6])  return {4'h0, m_ir[3:0]};
        if (cw[4])   return m_a;
        if (cw[2])   return alu[7:0];
        return 8'h00;
    endfunction

    function automatic logic exp_conflict(input logic [11:0] cw);
        int n;
        n = int'(cw[10]) + int'(!cw[8]) + int'(!cw[6]) + int'(cw[4]) + int'(cw[2]);
        return n > 1;
    endfunction

    task automatic mstep(input logic r, input logic [11:0] cw, input logic we,
                         input logic [3:0] addr, input logic [7:0] data);
        logic [7:0] bus;
        logic [8:0] alu;
        bus = exp_bus(cw);
        alu = alu_model(m_a, m_b, cw[3]);
        if (r) begin
            m_pc = 4'h0; m_mar = 4'h0; m_ir = 8'h00; m_a = 8'h00; m_b = 8'h00;
            m_out = 8'h00; m_halt = 1'b0; m_c = 1'b0; m_z = 1'b0;
            model_valid = 1'b1;
        end else begin
            if (we) m_ram[addr] = data;
            if (!m_halt) begin
                if (!cw[0]) m_out = m_a;
                if (cw[11]) m_pc = m_pc + 4'd1;
                if (!cw[9]) m_mar = bus[3:0];
                if (!cw[5]) m_a = bus;
                if (!cw[1]) m_b = bus;
                if (!cw[7]) begin
                    m_ir = bus;
                    if (bus[7:4] == 4'hF) m_halt = 1'b1;
                end
                if (!cw[5] && cw[2]) begin
                    m_c = alu[8];
                    m_z = (alu[7:0] == 8'h00);
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("w_bus", w_bus, exp_bus(cw_bus));
        chk("bus_conflict", {7'b0, bus_conflict}, {7'b0, exp_conflict(cw_bus)});
        chk("opcode", {4'b0, opcode}, {4'b0, m_ir[7:4]});
        chk("out_data", out_data, m_out);
        chk("halted", {7'b0, halted}, {7'b0, m_halt});
`ifdef SAP1_FLAGS_EN
        chk("carry_flag", {7'b0, carry_flag}, {7'b0, m_c});
        chk("zero_flag", {7'b0, zero_flag}, {7'b0, m_z});
`endif
    endtask

    // One clock: drive inputs, check at the falling edge, then advance the model.
    task automatic tick(input logic r, input logic [11:0] cw, input logic we,
                        input logic [3:0] addr, input logic [7:0] data,
                        input bit lit, input logic [7:0] lit_bus, input logic lit_cf,
                        input string name);
        rst = r; cw_bus = cw; prog_we = we; prog_addr = addr; prog_data = data;
        @(negedge clk);
        if (model_valid) compare_all();
        if (lit) begin
            chk(name, w_bus, lit_bus);
            chk({name, "_cf"}, {7'b0, bus_conflict}, {7'b0, lit_cf});
        end
        @(posedge clk);
        #1;
        mstep(r, cw, we, addr, data);
    endtask

    task automatic cyc(input logic [11:0] cw);
        tick(1'b0, cw, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, "");
    endtask

    task automatic do_reset();
        tick(1'b1, NOP, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, "");
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        tick(1'b0, NOP, 1'b1, a, d, 1'b0, 8'h00, 1'b0, "");
    endtask

    task automatic probe(input logic [11:0] cw, input logic [7:0] exp, input logic cf, input string name);
        tick(1'b0, cw, 1'b0, 4'h0, 8'h00, 1'b1, exp, cf, name);
    endtask

    function automatic logic [11:0] ucode(input int t, input logic [3:0] op);
        case (t)
            1: return 12'h5E3;
            2: return 12'hBE3;
            3: return 12'h263;
            4: return (op == 4'h0 || op == 4'h1 || op == 4'h2) ? 12'h1A3 :
                      (op == 4'hE) ? 12'h3F2 : NOP;
            5: return (op == 4'h0) ? 12'h2C3 :
                      (op == 4'h1 || op == 4'h2) ? 12'h2E1 : NOP;
            6: return (op == 4'h1) ? 12'h3C7 : (op == 4'h2) ? 12'h3CF : NOP;
            default: return NOP;
        endcase
    endfunction

    task automatic run_instr();
        for (int t = 1; t <= 6; t++) cyc(ucode(t, m_ir[7:4]));
    endtask

    logic [7:0] prog [16];

    initial begin
        prog = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h10, 8'h14, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 16; i++) wr(4'(i), prog[i]);
        do_reset();

        // Reset state.
        chk("rst_out", out_data, 8'h00);
        chk("rst_halted", {7'b0, halted}, 8'h00);
        chk("rst_opcode", {4'b0, opcode}, 8'h00);
        probe(RD_A, 8'h00, 1'b0, "rst_a");
        probe(RD_PC, 8'h00, 1'b0, "rst_pc");

        // Program-and-run: 0x10 + 0x14 - 0x18 = 0x0C.
        for (int k = 0; k < 3; k++) run_instr();
        chk("prog_out_before", out_data, 8'h00);
        run_instr();
        chk("prog_out", out_data, 8'h0C);
        run_instr();
        chk("prog_halted", {7'b0, halted}, 8'h01);

        // Halt freeze; prog_we still honoured.
        for (int k = 0; k < 10; k++)
            tick(1'b0, 12'hBC3, (k == 3), 4'h5, 8'h5A, 1'b0, 8'h00, 1'b0, "");
        probe(RD_PC, 8'h05, 1'b0, "halt_pc");
        probe(RD_A, 8'h0C, 1'b0, "halt_a");
        chk("halt_out", out_data, 8'h0C);
        chk("halt_still", {7'b0, halted}, 8'h01);

        // RAM[5] written while halted survives reset.
        do_reset();
        chk("rst_clears_halt", {7'b0, halted}, 8'h00);
        for (int k = 0; k < 5; k++) cyc(CP_ONE);
        cyc(12'h5E3);
        probe(RD_RAM, 8'h5A, 1'b0, "ram5_after_halt");

        // Reset during LDA T4 aborts it.
        do_reset();
        cyc(12'h5E3);
        cyc(12'hBE3);
        cyc(12'h263);
        tick(1'b1, 12'h1A3, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, "");
        probe(RD_A, 8'h00, 1'b0, "abort_a");
        probe(RD_PC, 8'h00, 1'b0, "abort_pc");
        probe(RD_OPR, 8'h00, 1'b0, "abort_ir_opr");
        chk("abort_opcode", {4'b0, opcode}, 8'h00);
        chk("abort_halted", {7'b0, halted}, 8'h00);
        probe(RD_RAM, 8'h09, 1'b0, "abort_ram0");

        // ADD wrap: 0xF0 + 0x20 = 0x10, carry out.
        wr(4'h0, 8'h0C); wr(4'h1, 8'h1D); wr(4'hC, 8'hF0); wr(4'hD, 8'h20);
        do_reset();
        run_instr(); run_instr();
        probe(RD_A, 8'h10, 1'b0, "add_wrap");
`ifdef SAP1_FLAGS_EN
        chk("add_carry", {7'b0, carry_flag}, 8'h01);
        chk("add_zero", {7'b0, zero_flag}, 8'h00);
`endif

        // SUB negative: 0x05 - 0x07 = 0xFE, borrow.
        wr(4'h0, 8'h0E); wr(4'h1, 8'h2F); wr(4'hE, 8'h05); wr(4'hF, 8'h07);
        do_reset();
        run_instr(); run_instr();
        probe(RD_A, 8'hFE, 1'b0, "sub_neg");
`ifdef SAP1_FLAGS_EN
        chk("sub_neg_carry", {7'b0, carry_flag}, 8'h00);
        chk("sub_neg_zero", {7'b0, zero_flag}, 8'h00);
`endif

        // SUB to zero: 0x07 - 0x07.
        wr(4'h1, 8'h2E); wr(4'hE, 8'h07);
        do_reset();
        run_instr(); run_instr();
        probe(RD_A, 8'h00, 1'b0, "sub_zero");
`ifdef SAP1_FLAGS_EN
        chk("sub_zero_carry", {7'b0, carry_flag}, 8'h01);
        chk("sub_zero_zero", {7'b0, zero_flag}, 8'h01);
`endif

        // Bus conflict with PC=3: Ep wins over CE.
        do_reset();
        for (int k = 0; k < 3; k++) cyc(CP_ONE);
        probe(12'h6E3, 8'h03, 1'b1, "conflict_bus");
        probe(12'h4E3, 8'h03, 1'b1, "conflict_load_mar");
        tick(1'b0, RD_RAM, 1'b1, 4'h3, 8'hE1, 1'b1, 8'hE0, 1'b0, "ram3_old_on_write");
        probe(RD_RAM, 8'hE1, 1'b0, "ram3_new");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
